// File: rtl/cpu_pkg.sv
// Shared processor definitions: fetch FSM states, PC width and the halt opcode.
package cpu_pkg;

    localparam int unsigned PC_W      = 12;
    localparam logic [8:0]  HALT_CODE = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode bus: instruction register handshake plus branch redirect from execute.
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int unsigned D = PC_W
);
    logic [8:0]   ir;
    logic [D-1:0] ir_pc;
    logic         ir_valid;
    logic         ir_ready;
    logic         br_taken;
    logic [D-1:0] br_target;

    modport master (
        output ir, ir_pc, ir_valid,
        input  ir_ready, br_taken, br_target
    );

    modport slave (
        input  ir, ir_pc, ir_valid,
        output ir_ready, br_taken, br_target
    );
endinterface

// File: rtl/fetch_unit_prog_counter.sv
// Program counter register: load has priority over increment; increment wraps mod 2^D.
module prog_counter
    import cpu_pkg::*;
#(
    parameter int unsigned D = PC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [D-1:0] load_val,
    input  logic         inc,
    output logic [D-1:0] pc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= '0;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + 1'b1;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, valid/ready to decode, branch redirect and halt.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned D         = PC_W,
    parameter logic [8:0]  HALT_CODE = cpu_pkg::HALT_CODE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [D-1:0]    start_addr,
    output logic [D-1:0]    prog_ctr,
    input  logic [8:0]      mach_code,
    output logic            done,
    fetch_unit_if.master    dec
);
    fetch_state_t state, state_next;

    logic         pc_load;
    logic [D-1:0] pc_load_val;
    logic         pc_inc;
    logic         ir_we;
    logic         valid_next;
    logic         fetch;

    prog_counter #(.D(D)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (prog_ctr)
    );

    assign fetch = (state == RUN) && (!dec.ir_valid || dec.ir_ready);
    assign done  = (state == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dec.ir       <= '0;
            dec.ir_pc    <= '0;
            dec.ir_valid <= 1'b0;
        end else begin
            state        <= state_next;
            dec.ir_valid <= valid_next;
            if (ir_we) begin
                dec.ir    <= mach_code;
                dec.ir_pc <= prog_ctr;
            end
        end
    end

    // A branch in RUN/DRAIN wins over fetch, stall and halt detection.
    always_comb begin
        state_next  = state;
        pc_load     = 1'b0;
        pc_load_val = dec.br_target;
        pc_inc      = 1'b0;
        ir_we       = 1'b0;
        valid_next  = dec.ir_valid;
        case (state)
            IDLE, HALTED: begin
                valid_next = 1'b0;
                if (start) begin
                    pc_load     = 1'b1;
                    pc_load_val = start_addr;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (dec.br_taken) begin
                    pc_load    = 1'b1;
                    valid_next = 1'b0;
                end else if (fetch) begin
                    ir_we      = 1'b1;
                    valid_next = 1'b1;
                    if (mach_code == HALT_CODE)
                        state_next = DRAIN;
                    else
                        pc_inc = 1'b1;
                end
            end
            DRAIN: begin
                if (dec.br_taken) begin
                    pc_load    = 1'b1;
                    valid_next = 1'b0;
                    state_next = RUN;
                end else if (dec.ir_valid && dec.ir_ready) begin
                    valid_next = 1'b0;
                    state_next = HALTED;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: run, stall, branch, wrap, halt and async reset.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] start_addr;
    logic [11:0] prog_ctr;
    logic [8:0]  mach_code;
    logic        done;
    logic [8:0]  rom [0:4095];

    int errors = 0;
    int checks = 0;

    fetch_unit_if #(.D(12)) bus ();

    fetch_unit #(.D(12), .HALT_CODE(9'h1FF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .prog_ctr   (prog_ctr),
        .mach_code  (mach_code),
        .done       (done),
        .dec        (bus.master)
    );

    assign mach_code = rom[prog_ctr];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        start         = 1'b0;
        start_addr    = '0;
        bus.ir_ready  = 1'b1;
        bus.br_taken  = 1'b0;
        bus.br_target = '0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_start(input logic [11:0] addr);
        start      = 1'b1;
        start_addr = addr;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.ir_valid); end
        checks++; if (prog_ctr !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h exp 000", prog_ctr); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (bus.ir !== 9'h000 || bus.ir_pc !== 12'h000) begin errors++; $display("FAIL reset_ir: got %h/%h exp 000/000", bus.ir, bus.ir_pc); end
        tick();
        checks++; if (bus.ir_valid !== 1'b0 || prog_ctr !== 12'h000) begin errors++; $display("FAIL idle_nofetch: got v=%b pc=%h exp v=0 pc=000", bus.ir_valid, prog_ctr); end
    endtask

    task automatic test_run();
        do_reset();
        for (int unsigned i = 0; i < 4; i++) rom[i] = 9'(i + 1);
        rom[4] = 9'h0A4;
        do_start(12'h000);
        checks++; if (bus.ir_valid !== 1'b0 || prog_ctr !== 12'h000) begin errors++; $display("FAIL start_load: got v=%b pc=%h exp v=0 pc=000", bus.ir_valid, prog_ctr); end
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir !== 9'(i + 1) || bus.ir_pc !== 12'(i)) begin
                errors++;
                $display("FAIL run_seq%0d: got v=%b ir=%h pc=%h exp v=1 ir=%h pc=%h", i, bus.ir_valid, bus.ir, bus.ir_pc, 9'(i + 1), 12'(i));
            end
        end
        start      = 1'b1;
        start_addr = 12'h300;
        tick();
        start      = 1'b0;
        checks++; if (bus.ir !== 9'h0A4 || bus.ir_pc !== 12'h004 || prog_ctr !== 12'h005) begin errors++; $display("FAIL start_ignored: got ir=%h irpc=%h pc=%h exp 0a4/004/005", bus.ir, bus.ir_pc, prog_ctr); end
    endtask

    task automatic test_stall_branch();
        do_reset();
        for (int unsigned i = 0; i < 4; i++) rom[i] = 9'(i + 1);
        rom[12'h100] = 9'h155;
        rom[12'h101] = 9'h156;
        rom[12'h200] = 9'h0C3;
        do_start(12'h000);
        tick();
        tick();
        checks++; if (bus.ir !== 9'h002 || bus.ir_pc !== 12'h001) begin errors++; $display("FAIL stall_pre: got ir=%h pc=%h exp 002/001", bus.ir, bus.ir_pc); end
        bus.ir_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.ir_valid !== 1'b1 || bus.ir !== 9'h002 || bus.ir_pc !== 12'h001 || prog_ctr !== 12'h002) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b ir=%h irpc=%h pc=%h exp 1/002/001/002", i, bus.ir_valid, bus.ir, bus.ir_pc, prog_ctr);
            end
        end
        bus.ir_ready = 1'b1;
        tick();
        checks++; if (bus.ir !== 9'h003 || bus.ir_pc !== 12'h002) begin errors++; $display("FAIL stall_resume: got ir=%h pc=%h exp 003/002", bus.ir, bus.ir_pc); end
        bus.br_taken  = 1'b1;
        bus.br_target = 12'h100;
        tick();
        bus.br_taken  = 1'b0;
        checks++; if (bus.ir_valid !== 1'b0 || prog_ctr !== 12'h100) begin errors++; $display("FAIL br_flush: got v=%b pc=%h exp 0/100", bus.ir_valid, prog_ctr); end
        tick();
        checks++; if (bus.ir_valid !== 1'b1 || bus.ir !== 9'h155 || bus.ir_pc !== 12'h100) begin errors++; $display("FAIL br_target: got v=%b ir=%h pc=%h exp 1/155/100", bus.ir_valid, bus.ir, bus.ir_pc); end
        bus.ir_ready  = 1'b0;
        bus.br_taken  = 1'b1;
        bus.br_target = 12'h200;
        tick();
        bus.br_taken  = 1'b0;
        bus.ir_ready  = 1'b1;
        checks++; if (bus.ir_valid !== 1'b0 || prog_ctr !== 12'h200) begin errors++; $display("FAIL br_stall_flush: got v=%b pc=%h exp 0/200", bus.ir_valid, prog_ctr); end
        tick();
        checks++; if (bus.ir !== 9'h0C3 || bus.ir_pc !== 12'h200) begin errors++; $display("FAIL br_stall_target: got ir=%h pc=%h exp 0c3/200", bus.ir, bus.ir_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        rom[12'hFFF] = 9'h011;
        rom[0]       = 9'h022;
        do_start(12'hFFF);
        tick();
        checks++; if (bus.ir !== 9'h011 || bus.ir_pc !== 12'hFFF || prog_ctr !== 12'h000) begin errors++; $display("FAIL wrap_last: got ir=%h irpc=%h pc=%h exp 011/fff/000", bus.ir, bus.ir_pc, prog_ctr); end
        tick();
        checks++; if (bus.ir !== 9'h022 || bus.ir_pc !== 12'h000) begin errors++; $display("FAIL wrap_first: got ir=%h irpc=%h exp 022/000", bus.ir, bus.ir_pc); end
    endtask

    task automatic test_halt();
        do_reset();
        rom[2] = 9'h0B2;
        rom[3] = 9'h033;
        rom[4] = 9'h044;
        rom[5] = 9'h1FF;
        rom[6] = 9'h066;
        do_start(12'h003);
        tick();
        tick();
        tick();
        checks++; if (bus.ir !== 9'h1FF || bus.ir_valid !== 1'b1 || prog_ctr !== 12'h005 || done !== 1'b0) begin errors++; $display("FAIL halt_load: got ir=%h v=%b pc=%h done=%b exp 1ff/1/005/0", bus.ir, bus.ir_valid, prog_ctr, done); end
        bus.ir_ready = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || bus.ir_valid !== 1'b1 || bus.ir !== 9'h1FF || prog_ctr !== 12'h005) begin
                errors++;
                $display("FAIL halt_drain%0d: got done=%b v=%b ir=%h pc=%h exp 0/1/1ff/005", i, done, bus.ir_valid, bus.ir, prog_ctr);
            end
        end
        bus.ir_ready = 1'b1;
        tick();
        checks++; if (done !== 1'b1 || bus.ir_valid !== 1'b0) begin errors++; $display("FAIL halt_accept: got done=%b v=%b exp 1/0", done, bus.ir_valid); end
        tick();
        checks++; if (done !== 1'b1 || bus.ir_valid !== 1'b0 || prog_ctr !== 12'h005) begin errors++; $display("FAIL halted_hold: got done=%b v=%b pc=%h exp 1/0/005", done, bus.ir_valid, prog_ctr); end
        do_start(12'h002);
        checks++; if (done !== 1'b0 || prog_ctr !== 12'h002) begin errors++; $display("FAIL restart: got done=%b pc=%h exp 0/002", done, prog_ctr); end
        tick();
        checks++; if (bus.ir !== 9'h0B2 || bus.ir_valid !== 1'b1 || bus.ir_pc !== 12'h002) begin errors++; $display("FAIL restart_fetch: got ir=%h v=%b irpc=%h exp 0b2/1/002", bus.ir, bus.ir_valid, bus.ir_pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int unsigned i = 0; i < 4; i++) rom[i] = 9'(i + 1);
        do_start(12'h001);
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ir_valid !== 1'b0 || prog_ctr !== 12'h000 || done !== 1'b0 || bus.ir !== 9'h000) begin errors++; $display("FAIL async_rst: got v=%b pc=%h done=%b ir=%h exp 0/000/0/000", bus.ir_valid, prog_ctr, done, bus.ir); end
        start      = 1'b1;
        start_addr = 12'h050;
        tick();
        checks++; if (prog_ctr !== 12'h000 || bus.ir_valid !== 1'b0) begin errors++; $display("FAIL rst_start_ignored: got pc=%h v=%b exp 000/0", prog_ctr, bus.ir_valid); end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (prog_ctr !== 12'h000 || bus.ir_valid !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got pc=%h v=%b exp 000/0", prog_ctr, bus.ir_valid); end
    endtask

    initial begin
        for (int unsigned i = 0; i < 4096; i++) rom[i] = '0;
        test_reset();
        test_run();
        test_stall_branch();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
